pow_share_ctrl: RTL and testbench
=================================

// Module: pow_share_ctrl
// PURPOSE
//  Round-robin arbiter/sequencer sharing one start/ready fast-exponentiation unit
//  (x**n mod 2**XW) among NREQ requesters. It latches the winning requester's
//  operands and pulses the unit's start. It waits for the unit's ready to fall and
//  then rise again, and returns the result with a one-cycle done pulse to the winner.
//  It sits between client FSMs and the exponentiation unit; the unit is instantiated
//  outside this block.
// PARAMETERS
//  NREQ  4   number of requesters (>=2)
//  XW    16  base/result width; must equal the unit's data width
//  NW    8   exponent width; must equal the unit's exponent width
// PORTS
//  clk       in   1              clock, all state changes on posedge
//  nrst      in   1              asynchronous active-low reset
//  req       in   NREQ           per-requester level request; held until its done
//  req_x     in   NREQ*XW        base for requester i in bits [i*XW +: XW]
//  req_n     in   NREQ*NW        exponent for requester i in bits [i*NW +: NW]
//  done      out  NREQ           one-hot one-cycle pulse: result for requester i valid
//  res       out  XW             result; valid while done!=0, held until next capture
//  busy      out  1              1 in any state other than IDLE
//  gnt_idx   out  $clog2(NREQ)   index of current/last granted requester
//  pw_start  out  1              start to unit (one-cycle pulse)
//  pw_x      out  XW             base to unit (latched operand)
//  pw_n      out  NW             exponent to unit (latched operand)
//  pw_ready  in   1              unit ready (1 = idle or finished)
//  pw_out    in   XW             unit result, valid when pw_ready returns to 1
// BEHAVIOUR
//  Reset (async, nrst=0): state=IDLE, done=0, pw_start=0, busy=0, res=0, gnt_idx=0,
//   rr_ptr=0, pw_x=0, pw_n=0. Reset mid-operation aborts with no done pulse. The
//   unit shares nrst, so the unit is back in ready too.
//  FSM (all registered transitions):
//   IDLE:      if |req && pw_ready: winner = first i with req[i]=1, scanning
//              rr_ptr, rr_ptr+1, ... (mod NREQ). Latch pw_x/pw_n from that slot,
//              gnt_idx<=winner, ->ISSUE. Otherwise stay; pw_ready=0 blocks a grant.
//   ISSUE:     pw_start=1 for exactly this cycle; ->WAIT_ACK.
//   WAIT_ACK:  pw_ready==0 -> WAIT_DONE; else stay. The unit drops ready the cycle
//              after start.
//   WAIT_DONE: pw_ready==1 -> res<=pw_out, ->RESP; else stay.
//   RESP:      done[gnt_idx]=1 for this cycle only; rr_ptr<=(gnt_idx+1)%NREQ; ->IDLE.
//  pw_start, done and busy are decoded from the state register (glitch-free, no
//   combinational input paths). pw_x/pw_n stay stable from ISSUE through RESP.
//  Latency: req first sampled in IDLE at cycle t -> pw_start at t+1 -> done at
//   t+3+B, where B is the unit's busy cycles (B=1 for n=0, B=2 for n=1).
//  Operand changes on req_x/req_n after the grant are ignored until the next grant.
//  Requester protocol: drop or re-raise req the cycle after done. If req is still
//   high in the next IDLE, it is treated as a new request. That request has the
//   lowest priority because rr_ptr has moved past it.
//  Deasserting req while granted does not cancel the operation. done still pulses.
//  Arithmetic: no widening; res is the unit's result truncated to XW bits.
//  Fairness: with all req high, grants follow rr_ptr order with no starvation.
//   Worst-case wait is NREQ-1 operations.
//  Wrap-around: rr_ptr wraps from NREQ-1 to 0. gnt_idx=NREQ-1 -> rr_ptr=0.
// TESTING
//  1 reset, req=0001, x0=3, n0=0 -> pw_start 1 cyc at t+1, done=0001 at t+4, res=1
//  2 req=0010, x1=3, n1=5 -> exactly one pw_start; done=0010; res=243; busy 1->0
//  3 req=0100, x2=2, n2=16 -> res=0 (16-bit wrap); x2=0xFFFF, n2=2 -> res=0x0001
//  4 after reset, req=1111, distinct x/n, each req dropped after its done
//    -> done order 0,1,2,3 with correct results; re-raise req0 only -> served next
//  5 req=1001 held continuously, rr_ptr=3 -> grant 3, then 0, then 3 (alternating)
//  6 nrst=0 during WAIT_DONE -> done never pulses; all outputs at reset values
//    while nrst=0; next req is served normally from rr_ptr=0

Source files
------------

// File: rtl/pow_share_ctrl.sv
// pow_share_ctrl: round-robin sequencer that shares one start/ready
// fast-exponentiation unit among NREQ requesters. The winner's operands are
// latched and start is pulsed. The block waits for ready to fall and rise
// again, then returns the result to the winner with a one-cycle done pulse.
module pow_share_ctrl #(
  parameter  int NREQ = 4,
  parameter  int XW   = 16,
  parameter  int NW   = 8,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*XW-1:0] req_x,
  input  logic [NREQ*NW-1:0] req_n,
  output logic [NREQ-1:0]    done,
  output logic [XW-1:0]      res,
  output logic               busy,
  output logic [IW-1:0]      gnt_idx,
  output logic               pw_start,
  output logic [XW-1:0]      pw_x,
  output logic [NW-1:0]      pw_n,
  input  logic               pw_ready,
  input  logic [XW-1:0]      pw_out
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   gnt_idx_r;
  logic [XW-1:0]   pw_x_r;
  logic [NW-1:0]   pw_n_r;
  logic [XW-1:0]   res_r;
  logic [IW-1:0]   win_idx_s;
  logic            win_vld_s;
  logic [IW:0]     cand_s;
  logic [NREQ-1:0] done_s;
  logic            grant_s;

  // Round-robin search: first active request at or after rr_ptr, wrapping.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = '0;
    cand_s    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (IW+1)'(k);
      if (cand_s >= (IW+1)'(NREQ)) begin
        cand_s = cand_s - (IW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!win_vld_s && req[cand_s[IW-1:0]]) begin
        win_vld_s = 1'b1;
        win_idx_s = cand_s[IW-1:0];
      end else begin
        win_vld_s = win_vld_s;
        win_idx_s = win_idx_s;
      end
    end
  end

  // A grant needs a pending request and an idle unit.
  assign grant_s = win_vld_s && pw_ready;

  // Next-state logic of the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!pw_ready) begin
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (pw_ready) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture on grant, result capture on ready, pointer advance on response.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr_r  <= '0;
      gnt_idx_r <= '0;
      pw_x_r    <= '0;
      pw_n_r    <= '0;
      res_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            gnt_idx_r <= win_idx_s;
            pw_x_r    <= req_x[int'(win_idx_s)*XW +: XW];
            pw_n_r    <= req_n[int'(win_idx_s)*NW +: NW];
          end
        end
        ST_WAIT_DONE: begin
          if (pw_ready) begin
            res_r <= pw_out;
          end
        end
        ST_RESP: begin
          if (gnt_idx_r == IW'(NREQ - 1)) begin
            rr_ptr_r <= '0;
          end else begin
            rr_ptr_r <= gnt_idx_r + IW'(1);
          end
        end
        default: begin
          rr_ptr_r <= rr_ptr_r;
        end
      endcase
    end
  end

  // One-hot done decoded from the state register only.
  always_comb begin
    done_s = '0;
    if (state_r == ST_RESP) begin
      done_s[gnt_idx_r] = 1'b1;
    end else begin
      done_s = '0;
    end
  end

  assign done     = done_s;
  assign pw_start = (state_r == ST_ISSUE);
  assign busy     = (state_r != ST_IDLE);
  assign res      = res_r;
  assign gnt_idx  = gnt_idx_r;
  assign pw_x     = pw_x_r;
  assign pw_n     = pw_n_r;

endmodule

// File: tb/tb_pow_share_ctrl.sv
// Testbench for pow_share_ctrl: behavioural exponentiation unit, directed
// scenarios, then randomized traffic checked against a round-robin model.
module tb_pow_share_ctrl;
  localparam int NREQ = 4;
  localparam int XW   = 16;
  localparam int NW   = 8;
  localparam int IW   = 2;

  logic               clk = 1'b0;
  logic               nrst;
  logic [NREQ-1:0]    req;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ*NW-1:0] req_n;
  logic [NREQ-1:0]    done;
  logic [XW-1:0]      res;
  logic               busy;
  logic [IW-1:0]      gnt_idx;
  logic               pw_start;
  logic [XW-1:0]      pw_x;
  logic [NW-1:0]      pw_n;
  logic               pw_ready;
  logic [XW-1:0]      pw_out;

  int checks = 0;
  int errors = 0;
  int unsigned u_cnt;
  int unsigned extra_lat = 0;

  pow_share_ctrl #(.NREQ(NREQ), .XW(XW), .NW(NW)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_x(req_x), .req_n(req_n),
    .done(done), .res(res), .busy(busy), .gnt_idx(gnt_idx),
    .pw_start(pw_start), .pw_x(pw_x), .pw_n(pw_n),
    .pw_ready(pw_ready), .pw_out(pw_out)
  );

  always #5 clk = ~clk;

  // x**n truncated to 16 bits by plain repeated multiplication.
  function automatic logic [15:0] ref_pow(input logic [15:0] x, input logic [7:0] n);
    logic [15:0] r;
    r = 16'd1;
    for (int i = 0; i < int'(n); i++) r = r * x;
    return r;
  endfunction

  function automatic int bitlen(input logic [7:0] n);
    int b;
    b = 0;
    for (int i = 0; i < 8; i++) if (n[i]) b = i + 1;
    return b;
  endfunction

  // Behavioural unit: ready drops the cycle after start, stays low 1+bitlen(n)+extra cycles.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pw_ready <= 1'b1;
      pw_out   <= 16'd0;
      u_cnt    <= 0;
    end else if (pw_start) begin
      pw_ready <= 1'b0;
      pw_out   <= ref_pow(pw_x, pw_n);
      u_cnt    <= 1 + bitlen(pw_n) + extra_lat;
    end else if (!pw_ready) begin
      if (u_cnt <= 1) pw_ready <= 1'b1;
      else u_cnt <= u_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setop(input int i, input logic [15:0] x, input logic [7:0] n);
    req_x[i*XW +: XW] = x;
    req_n[i*NW +: NW] = n;
  endtask

  // Waits (bounded) for a done pulse; reports cycles, start pulses and first start cycle.
  task automatic wait_done(input int limit, output logic [3:0] d, output logic [15:0] r,
                           output logic [1:0] g, output int cyc, output int starts,
                           output int st_cyc);
    d = 4'd0; r = 16'd0; g = 2'd0; cyc = 0; starts = 0; st_cyc = -1;
    while (d == 4'd0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (pw_start) begin
        starts++;
        if (st_cyc < 0) st_cyc = cyc;
      end
      if (done != 4'd0) begin
        d = done; r = res; g = gnt_idx;
      end
    end
    chk("done_seen", 32'(d != 4'd0), 32'd1);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req  = 4'd0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  d;
    logic [15:0] r;
    logic [1:0]  g;
    int          cyc, starts, st_cyc, seen, rr_m, w;
    logic [3:0]  pm;
    logic [15:0] ox [4];
    logic [7:0]  on [4];
    logic [15:0] ev [4];

    nrst = 1'b0; req = 4'd0; req_x = '0; req_n = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(pw_start), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_gnt", 32'(gnt_idx), 32'd0);
    chk("rst_pwx", 32'(pw_x), 32'd0);
    chk("rst_pwn", 32'(pw_n), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // 1: latency and n=0
    setop(0, 16'd3, 8'd0);
    req = 4'b0001;
    wait_done(50, d, r, g, cyc, starts, st_cyc);
    chk("t1_done", 32'(d), 32'h1);
    chk("t1_res", 32'(r), 32'd1);
    chk("t1_lat", 32'(cyc), 32'd4);
    chk("t1_stcyc", 32'(st_cyc), 32'd1);
    chk("t1_starts", 32'(starts), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_pulse", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: 3**5, operands changed after grant are ignored
    setop(1, 16'd3, 8'd5);
    req = 4'b0010;
    @(negedge clk);
    chk("t2_start", 32'(pw_start), 32'd1);
    setop(1, 16'd7, 8'd7);
    wait_done(50, d, r, g, cyc, starts, st_cyc);
    chk("t2_done", 32'(d), 32'h2);
    chk("t2_res", 32'(r), 32'd243);
    chk("t2_starts", 32'(starts), 32'd0);
    chk("t2_busy1", 32'(busy), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    chk("t2_busy0", 32'(busy), 32'd0);

    // 3: 16-bit wrap
    setop(2, 16'd2, 8'd16);
    req = 4'b0100;
    wait_done(80, d, r, g, cyc, starts, st_cyc);
    chk("t3a_gnt", 32'(g), 32'd2);
    chk("t3a_res", 32'(r), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    setop(2, 16'hFFFF, 8'd2);
    req = 4'b0100;
    wait_done(80, d, r, g, cyc, starts, st_cyc);
    chk("t3b_res", 32'(r), 32'h0001);
    req = 4'b0000;
    @(negedge clk);

    // 4: all requesting after reset -> 0,1,2,3, then req0 alone
    do_reset();
    setop(0, 16'd3, 8'd4); setop(1, 16'd5, 8'd3);
    setop(2, 16'd7, 8'd2); setop(3, 16'd2, 8'd10);
    ev[0] = 16'd81; ev[1] = 16'd125; ev[2] = 16'd49; ev[3] = 16'd1024;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_done(80, d, r, g, cyc, starts, st_cyc);
      chk("t4_done", 32'(d), 32'(1 << i));
      chk("t4_res", 32'(r), 32'(ev[i]));
      req[i] = 1'b0;
    end
    setop(0, 16'd10, 8'd3);
    req = 4'b0001;
    wait_done(80, d, r, g, cyc, starts, st_cyc);
    chk("t4_regnt", 32'(g), 32'd0);
    chk("t4_reres", 32'(r), 32'd1000);
    req = 4'b0000;
    @(negedge clk);

    // 5: move pointer to 3, then hold 1001 -> 3,0,3
    setop(2, 16'd1, 8'd1);
    req = 4'b0100;
    wait_done(80, d, r, g, cyc, starts, st_cyc);
    req = 4'b0000;
    @(negedge clk);
    setop(3, 16'd3, 8'd3); setop(0, 16'd2, 8'd2);
    req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      wait_done(80, d, r, g, cyc, starts, st_cyc);
      chk("t5_gnt", 32'(g), (i == 1) ? 32'd0 : 32'd3);
      chk("t5_res", 32'(r), (i == 1) ? 32'd4 : 32'd27);
    end
    req = 4'b0000;
    @(negedge clk);

    // 6: reset during WAIT_DONE aborts; pointer returns to 0
    setop(1, 16'd2, 8'd1);
    req = 4'b0010;
    wait_done(80, d, r, g, cyc, starts, st_cyc);
    req = 4'b0000;
    @(negedge clk);
    setop(2, 16'd3, 8'hC8);
    req = 4'b0100;
    cyc = 0;
    while (!pw_start && cyc < 20) begin @(negedge clk); cyc++; end
    chk("t6_start", 32'(pw_start), 32'd1);
    repeat (3) @(negedge clk);
    chk("t6_inflight", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_start0", 32'(pw_start), 32'd0);
    chk("t6_res", 32'(res), 32'd0);
    chk("t6_gnt", 32'(gnt_idx), 32'd0);
    chk("t6_pwx", 32'(pw_x), 32'd0);
    chk("t6_pwn", 32'(pw_n), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (done != 4'd0) seen++; end
    chk("t6_nodone", 32'(seen), 32'd0);
    setop(1, 16'd6, 8'd2); setop(3, 16'd4, 8'd3);
    req = 4'b1010;
    wait_done(80, d, r, g, cyc, starts, st_cyc);
    chk("t6_gnt1", 32'(g), 32'd1);
    chk("t6_res1", 32'(r), 32'd36);
    req = 4'b1000;
    wait_done(80, d, r, g, cyc, starts, st_cyc);
    chk("t6_gnt3", 32'(g), 32'd3);
    chk("t6_res3", 32'(r), 32'd64);
    req = 4'b0000;
    @(negedge clk);

    // Random traffic against a round-robin model
    do_reset();
    rr_m = 0;
    for (int i = 0; i < 4; i++) begin
      ox[i] = 16'($urandom);
      on[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      setop(i, ox[i], on[i]);
    end
    pm = 4'($urandom_range(1, 15));
    req = pm;
    for (int op = 0; op < 60; op++) begin
      w = -1;
      for (int k = 0; k < 4; k++) if (w < 0 && pm[(rr_m + k) % 4]) w = (rr_m + k) % 4;
      wait_done(200, d, r, g, cyc, starts, st_cyc);
      chk("rnd_done", 32'(d), 32'(1 << w));
      chk("rnd_gnt", 32'(g), 32'(w));
      chk("rnd_res", 32'(r), 32'(ref_pow(ox[w], on[w])));
      rr_m = (w + 1) % 4;
      pm[w] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!pm[i] && $urandom_range(0, 2) == 0) begin
          ox[i] = 16'($urandom);
          on[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
          setop(i, ox[i], on[i]);
          pm[i] = 1'b1;
        end
      end
      if (pm == 4'd0) begin
        w = int'($urandom_range(0, 3));
        ox[w] = 16'($urandom);
        on[w] = 8'($urandom_range(0, 12));
        setop(w, ox[w], on[w]);
        pm[w] = 1'b1;
      end
      req = pm;
      extra_lat = $urandom_range(0, 3);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
